// File: rtl/work_loader.sv
// Work-packet front end for block_solver: collects a 44-byte packet, expands nBits
// into a 256-bit target, commits the work atomically and restarts the solver.
module work_loader #(
   parameter int SOLVER_RST_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_data,
   input  logic         in_sof,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [255:0] midstate,
   output logic [95:0]  header_leftovers,
   output logic [255:0] target,
   output logic         solver_rst_n,
   output logic         work_valid,
   output logic         bits_error
);

   localparam int RC_W = (SOLVER_RST_CYCLES < 1) ? 1 : $clog2(SOLVER_RST_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, RECV, EXPAND, RESTART} state_t;

   state_t         state;
   logic [5:0]     count;
   logic [351:0]   shadow;
   logic [255:0]   shadow_target;
   logic [7:0]     exp_cnt;
   logic           first;
   logic [RC_W-1:0] rst_cnt;

   logic           accept;
   logic [351:0]   shadow_next;
   logic [7:0]     nbits_exp;
   logic [23:0]    nbits_mant;
   logic           bits_bad;

   // Bytes arrive in big-endian position order, so a left-shifting register lands
   // byte 0 at the top of the midstate after the 44th byte.
   assign accept      = in_valid && in_ready;
   assign shadow_next = {shadow[343:0], in_data};

   // nBits is the byte-reversed last word of the header tail.
   assign nbits_exp  = shadow[7:0];
   assign nbits_mant = {shadow[15:8], shadow[23:16], shadow[31:24]};
   assign bits_bad   = (nbits_exp > 8'd32) || nbits_mant[23] ||
                       ((nbits_mant == 24'd0) && (nbits_exp != 8'd0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         count            <= 6'd0;
         shadow           <= '0;
         shadow_target    <= '0;
         exp_cnt          <= 8'd0;
         first            <= 1'b0;
         rst_cnt          <= '0;
         in_ready         <= 1'b0;
         midstate         <= '0;
         header_leftovers <= '0;
         target           <= '0;
         solver_rst_n     <= 1'b0;
         work_valid       <= 1'b0;
         bits_error       <= 1'b0;
      end else begin
         bits_error <= 1'b0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept && in_sof) begin
                  shadow <= shadow_next;
                  count  <= 6'd1;
                  state  <= RECV;
               end
            end

            RECV: begin
               in_ready <= 1'b1;
               if (accept) begin
                  shadow <= shadow_next;
                  if (in_sof) begin
                     count <= 6'd1;
                  end else if (count == 6'd43) begin
                     count    <= 6'd0;
                     in_ready <= 1'b0;
                     first    <= 1'b1;
                     state    <= EXPAND;
                  end else begin
                     count <= count + 6'd1;
                  end
               end
            end

            EXPAND: begin
               in_ready <= 1'b0;
               if (first) begin
                  first <= 1'b0;
                  if (bits_bad) begin
                     bits_error <= 1'b1;
                     in_ready   <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     shadow_target <= {232'b0, nbits_mant};
                     exp_cnt       <= nbits_exp;
                  end
               end else if (exp_cnt > 8'd3) begin
                  shadow_target <= shadow_target << 8;
                  exp_cnt       <= exp_cnt - 8'd1;
               end else if (exp_cnt < 8'd3) begin
                  shadow_target <= shadow_target >> 8;
                  exp_cnt       <= exp_cnt + 8'd1;
               end else begin
                  // Single-cycle commit keeps the solver's view of the work consistent.
                  midstate         <= shadow[351:96];
                  header_leftovers <= shadow[95:0];
                  target           <= shadow_target;
                  work_valid       <= 1'b1;
                  solver_rst_n     <= 1'b0;
                  rst_cnt          <= RC_W'(1);
                  state            <= RESTART;
               end
            end

            RESTART: begin
               in_ready <= 1'b0;
               if (rst_cnt >= RC_W'(SOLVER_RST_CYCLES)) begin
                  solver_rst_n <= 1'b1;
                  in_ready     <= 1'b1;
                  state        <= IDLE;
               end else begin
                  rst_cnt <= rst_cnt + RC_W'(1);
               end
            end

            default: begin
               in_ready <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_work_loader.sv
// Directed bench for work_loader: packet reception, nBits expansion, commit timing,
// invalid nBits, sof resync, reset during expansion and in_valid gaps.
module tb_work_loader;

   logic         clk;
   logic         rst;
   logic [7:0]   in_data;
   logic         in_sof;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] midstate;
   logic [95:0]  header_leftovers;
   logic [255:0] target;
   logic         solver_rst_n;
   logic         work_valid;
   logic         bits_error;

   int compared   = 0;
   int mismatched = 0;

   work_loader #(.SOLVER_RST_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
      .in_ready(in_ready), .midstate(midstate), .header_leftovers(header_leftovers),
      .target(target), .solver_rst_n(solver_rst_n), .work_valid(work_valid),
      .bits_error(bits_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [255:0] MID_A = 256'h4a03aeb2_11223344_55667788_99aabbcc_0f1e2d3c_4b5a6978_8796a5b4_ddef7254;
   localparam logic [95:0]  LEFT_A = 96'h15274c646c51f957c4400418;
   localparam logic [255:0] TGT_A = 256'h0000_0000_0000_0000_0440_c400_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000;
   localparam logic [255:0] MID_B = {8{32'hb0b1b2b3}};
   localparam logic [95:0]  LEFT_B = 96'h01020304_05060708_56341203;
   localparam logic [255:0] MID_C = {8{32'hc0c1c2c3}};
   localparam logic [95:0]  LEFT_C = 96'h0a0b0c0d_0e0f1011_00001201;
   localparam logic [255:0] MID_D = {8{32'hd0d1d2d3}};
   localparam logic [95:0]  LEFT_D = 96'h21222324_25262728_00008021;
   localparam logic [255:0] MID_X = {8{32'h5a5a5a5a}};
   localparam logic [255:0] MID_E = {8{32'he0e1e2e3}};
   localparam logic [95:0]  LEFT_E = 96'h31323334_35363738_ffff0004;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic sof, input bit gap);
      bit acc;
      int n;
      @(negedge clk);
      if (gap) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_data  = b;
      in_sof   = sof;
      in_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 60) begin
         acc = in_ready;
         @(posedge clk);
         n++;
         if (!acc) @(negedge clk);
      end
      compared++;
      assert (acc) else begin
         mismatched++;
         $error("FAIL byte_accept_timeout observed=%0d expected=1", acc);
      end
   endtask

   task automatic send_packet(input logic [255:0] mid, input logic [95:0] left,
                              input int nbytes, input bit gap);
      for (int i = 0; i < nbytes; i++) begin
         if (i < 32) send_byte(mid[8*(31-i) +: 8], (i == 0), gap);
         else        send_byte(left[8*(43-i) +: 8], 1'b0, gap);
      end
   endtask

   // Counts negedges after the last accepted byte until target shows exp.
   task automatic wait_target(input logic [255:0] exp, output int n);
      n = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         n++;
      end while (target !== exp && n < 100);
   endtask

   task automatic check_restart(input string tag);
      check({tag, "_srn_low1"}, 256'(solver_rst_n), 256'd0);
      @(negedge clk);
      check({tag, "_srn_low2"}, 256'(solver_rst_n), 256'd0);
      @(negedge clk);
      check({tag, "_srn_high"}, 256'(solver_rst_n), 256'd1);
   endtask

   int lat;
   int pulses;

   initial begin
      rst = 1'b1; in_data = 8'h00; in_sof = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_midstate", midstate, 256'd0);
      check("rst_leftovers", 256'(header_leftovers), 256'd0);
      check("rst_target", target, 256'd0);
      check("rst_srn", 256'(solver_rst_n), 256'd0);
      check("rst_work_valid", 256'(work_valid), 256'd0);
      check("rst_bits_error", 256'(bits_error), 256'd0);
      check("rst_in_ready", 256'(in_ready), 256'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 256'(in_ready), 256'd1);
      check("idle_srn_held", 256'(solver_rst_n), 256'd0);

      // Packet A, back to back, exp 24
      send_packet(MID_A, LEFT_A, 44, 1'b0);
      wait_target(TGT_A, lat);
      check("A_latency", 256'(lat), 256'd24);
      check("A_target", target, TGT_A);
      check("A_midstate", midstate, MID_A);
      check("A_leftovers", 256'(header_leftovers), 256'(LEFT_A));
      check("A_work_valid", 256'(work_valid), 256'd1);
      check_restart("A");

      // Packet B, exp 3, no shifts
      send_packet(MID_B, LEFT_B, 44, 1'b0);
      check("B_srn_before", 256'(solver_rst_n), 256'd1);
      check("B_target_held", target, TGT_A);
      wait_target(256'h123456, lat);
      check("B_latency", 256'(lat), 256'd3);
      check("B_target", target, 256'h123456);
      check("B_midstate", midstate, MID_B);
      check_restart("B");

      // Packet C, exp 1, right shift
      send_packet(MID_C, LEFT_C, 44, 1'b0);
      wait_target(256'h12, lat);
      check("C_latency", 256'(lat), 256'd5);
      check("C_target", target, 256'h12);
      check("C_leftovers", 256'(header_leftovers), 256'(LEFT_C));
      check_restart("C");

      // Packet D, mant[23] set: dropped
      send_packet(MID_D, LEFT_D, 44, 1'b0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (bits_error) pulses++;
      end
      check("D_bits_error_pulses", 256'(pulses), 256'd1);
      check("D_target_kept", target, 256'h12);
      check("D_midstate_kept", midstate, MID_C);
      check("D_leftovers_kept", 256'(header_leftovers), 256'(LEFT_C));
      check("D_work_valid", 256'(work_valid), 256'd1);
      check("D_srn", 256'(solver_rst_n), 256'd1);
      check("D_in_ready", 256'(in_ready), 256'd1);

      // Partial packet X resynced by sof, then packet E (exp 4)
      send_packet(MID_X, LEFT_E, 20, 1'b0);
      send_packet(MID_E, LEFT_E, 44, 1'b0);
      wait_target(256'hffff00, lat);
      check("E_latency", 256'(lat), 256'd4);
      check("E_target", target, 256'hffff00);
      check("E_midstate", midstate, MID_E);
      check_restart("E");

      // Reset during expansion of packet A
      send_packet(MID_A, LEFT_A, 44, 1'b0);
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("R_midstate", midstate, 256'd0);
      check("R_target", target, 256'd0);
      check("R_leftovers", 256'(header_leftovers), 256'd0);
      check("R_srn", 256'(solver_rst_n), 256'd0);
      check("R_work_valid", 256'(work_valid), 256'd0);
      check("R_in_ready", 256'(in_ready), 256'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("R_target_stays", target, 256'd0);

      // Packet A again with random in_valid gaps
      send_packet(MID_A, LEFT_A, 44, 1'b1);
      wait_target(TGT_A, lat);
      check("G_latency", 256'(lat), 256'd24);
      check("G_target", target, TGT_A);
      check("G_midstate", midstate, MID_A);
      check("G_leftovers", 256'(header_leftovers), 256'(LEFT_A));
      check("G_work_valid", 256'(work_valid), 256'd1);
      check_restart("G");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
